wb_arbiter: RTL

Writeback-port arbiter between the single-cycle EX path and the multi-cycle multiply/divide unit (MDU). It shares the regfile write port and the HI/LO write port between the two sources. EX traffic always has priority. MDU results queue in a small FIFO and drain in cycles where EX does not use the port they need. A starvation counter raises a stall request so the pipeline inserts a bubble and the queued result can retire.

---
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Shares the regfile write port and the HI/LO write port between the
//   single-cycle EX path and the multi-cycle MDU. EX always wins.
//
//   MDU results wait in a DEPTH-entry FIFO. The head drains in any cycle
//   where EX does not use a port the head needs. A starvation counter
//   raises stallreq so the pipeline inserts a bubble and the head can
//   retire.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   ex_*                     EX regfile write (wd/wreg/wdata) and HI/LO write (hi/lo/whilo)
//   mdu_valid / mdu_ready    MDU result handshake; a transfer enqueues all six mdu_* fields
//   mdu_*                    MDU result fields, same meaning as the ex_* fields
//   stallreq                 asks the pipeline for a bubble
//   wb_*                     registered merged regfile and HI/LO writes
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wd,
    input  logic        mdu_wreg,
    input  logic [31:0] mdu_wdata,
    input  logic [31:0] mdu_hi,
    input  logic [31:0] mdu_lo,
    input  logic        mdu_whilo,
    output logic        stallreq,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_whilo
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } ent_t;

    ent_t          mem_q [DEPTH];
    ent_t          mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    ent_t          wb_q, wb_d;

    ent_t head;
    logic nonempty, conflict, issue, enq;

    assign mdu_ready = (count_q != CW'(DEPTH));
    assign stallreq  = (wait_q == WW'(STARVE_MAX));
    assign nonempty  = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign enq       = mdu_valid & mdu_ready;

    assign conflict  = nonempty & ((head.wreg & ex_wreg) | (head.whilo & ex_whilo));
    // While stallreq is up the pipeline keeps EX idle, so conflict is already
    // clear and the head issues. Gating on conflict alone also keeps the head
    // intact if upstream ever writes during a stall: it is never split.
    assign issue     = nonempty & ~conflict;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wait_d   = wait_q;
        wb_d     = '0;

        if (enq) begin
            mem_d[wr_ptr_q] = '{wd: mdu_wd, wreg: mdu_wreg, wdata: mdu_wdata,
                                hi: mdu_hi, lo: mdu_lo, whilo: mdu_whilo};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({enq, issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (!nonempty || issue)
            wait_d = '0;
        else if (wait_q != WW'(STARVE_MAX))
            wait_d = wait_q + 1'b1;

        // Each port is merged independently, so one cycle can carry an EX
        // regfile write together with an MDU HI/LO write, or the reverse.
        if (ex_wreg) begin
            wb_d.wreg  = 1'b1;
            wb_d.wd    = ex_wd;
            wb_d.wdata = ex_wdata;
        end else if (issue && head.wreg) begin
            wb_d.wreg  = 1'b1;
            wb_d.wd    = head.wd;
            wb_d.wdata = head.wdata;
        end

        if (ex_whilo) begin
            wb_d.whilo = 1'b1;
            wb_d.hi    = ex_hi;
            wb_d.lo    = ex_lo;
        end else if (issue && head.whilo) begin
            wb_d.whilo = 1'b1;
            wb_d.hi    = head.hi;
            wb_d.lo    = head.lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            wb_q     <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            wb_q     <= wb_d;
        end
    end

    assign wb_wd    = wb_q.wd;
    assign wb_wreg  = wb_q.wreg;
    assign wb_wdata = wb_q.wdata;
    assign wb_hi    = wb_q.hi;
    assign wb_lo    = wb_q.lo;
    assign wb_whilo = wb_q.whilo;

endmodule
